// File: rtl/ovl_win_change_checker.sv
// ovl_win_change_checker: checks that test_expr changes at least once inside a
// start_event/end_event window. fire[0] flags a window that closed unchanged,
// fire[1] flags X/Z on test_expr inside a window, fire[2] marks a window opening.
module ovl_win_change_checker #(
   parameter int unsigned width     = 1,
   parameter int unsigned xcheck_en = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             start_event,
   input  logic [width-1:0] test_expr,
   input  logic             end_event,
   output logic [2:0]       fire
);

   typedef enum logic {
      IDLE   = 1'b0,
      WINDOW = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic               changed_q, changed_d;
   logic [width-1:0]   prev_q, prev_d;
   logic [2:0]         fire_q, fire_d;

   logic               expr_xz_c;
   logic               prev_xz_c;
   logic               expr_diff_c;

   // X/Z detection on the live sample and on the stored previous sample
   assign expr_xz_c = $isunknown(test_expr);
   assign prev_xz_c = $isunknown(prev_q);

   // A change only counts when both samples are fully known and differ
   assign expr_diff_c = ~expr_xz_c & ~prev_xz_c & (test_expr != prev_q);

   // Next-state, sticky change flag and fire pulse generation
   always_comb begin
      state_d   = state_q;
      changed_d = changed_q;
      prev_d    = prev_q;
      fire_d    = 3'b000;
      if (enable) begin
         prev_d = test_expr;
         case (state_q)
            IDLE: begin
               // end_event is deliberately ignored while no window is open
               if (start_event) begin
                  state_d   = WINDOW;
                  changed_d = 1'b0;
                  fire_d[2] = 1'b1;
               end
            end
            WINDOW: begin
               fire_d[1] = (xcheck_en != 0) && expr_xz_c;
               if (end_event) begin
                  // A change in the closing cycle still satisfies the window
                  fire_d[0] = ~(changed_q | expr_diff_c);
                  state_d   = IDLE;
               end else begin
                  changed_d = changed_q | expr_diff_c;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, flag, previous-sample and fire registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         changed_q <= 1'b0;
         prev_q    <= '0;
         fire_q    <= 3'b000;
      end else begin
         state_q   <= state_d;
         changed_q <= changed_d;
         prev_q    <= prev_d;
         fire_q    <= fire_d;
      end
   end

   assign fire = fire_q;

endmodule

// File: tb/tb_ovl_win_change_checker.sv
// Bench for ovl_win_change_checker: directed scenarios followed by random
// traffic, compared against a window-level behavioural model.
module tb_ovl_win_change_checker;

   localparam int unsigned W = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic         start_event = 1'b0;
   logic         end_event = 1'b0;
   logic [W-1:0] test_expr = '0;
   logic [2:0]   fire;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: is a window open, has it seen a change, last sample, expected fire
   bit           m_open = 1'b0;
   bit           m_seen = 1'b0;
   logic [W-1:0] m_prev = '0;
   logic [2:0]   m_fire = 3'b000;

   ovl_win_change_checker #(.width(W), .xcheck_en(1)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .start_event(start_event),
      .test_expr  (test_expr),
      .end_event  (end_event),
      .fire       (fire)
   );

   always #5 clock = ~clock;

   // Compute what the next rising edge must produce from the current inputs
   task automatic model_edge();
      bit xz, moved;
      if (reset) begin
         m_open = 0; m_seen = 0; m_prev = '0; m_fire = 3'b000;
         return;
      end
      m_fire = 3'b000;
      if (!enable) return;
      xz    = $isunknown(test_expr);
      moved = !xz && !$isunknown(m_prev) && (test_expr != m_prev);
      if (!m_open) begin
         if (start_event) begin
            m_open    = 1;
            m_seen    = 0;
            m_fire[2] = 1'b1;
         end
      end else begin
         m_fire[1] = xz;
         if (end_event) begin
            m_fire[0] = !(m_seen || moved);
            m_open    = 0;
         end else if (moved) begin
            m_seen = 1;
         end
      end
      m_prev = test_expr;
   endtask

   task automatic check(input string tag);
      vectors++;
      assert (fire === m_fire) else begin
         miscompares++;
         $error("FAIL %s: fire=%b expected %b", tag, fire, m_fire);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check after the next rising edge
   task automatic step(input logic en, input logic st, input logic ee,
                       input logic [W-1:0] te, input string tag);
      enable      = en;
      start_event = st;
      end_event   = ee;
      test_expr   = te;
      model_edge();
      @(posedge clock);
      @(negedge clock);
      check(tag);
   endtask

   // Asynchronous reset assertion: outputs must clear without a clock edge
   task automatic async_reset(input string tag);
      reset = 1'b1;
      #1;
      m_open = 0; m_seen = 0; m_prev = '0; m_fire = 3'b000;
      check(tag);
   endtask

   initial begin
      logic [W-1:0] xval;
      @(negedge clock);
      // Reset held with arbitrary inputs
      for (int i = 0; i < 3; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), "rst_held");
      reset = 1'b0;

      // Activity with no window open
      step(1, 0, 0, 4'b0000, "idle_zero");
      step(1, 0, 0, 4'b0101, "idle_change");
      step(1, 0, 1, 4'b0101, "idle_end_only");

      // start_event for 2 cycles, change, end 4 cycles later
      step(1, 1, 0, 4'b0101, "open");
      step(1, 1, 0, 4'b0101, "restart_ignored");
      step(1, 0, 0, 4'b1010, "change");
      step(1, 0, 0, 4'b1010, "win_hold1");
      step(1, 0, 0, 4'b1010, "win_hold2");
      step(1, 0, 1, 4'b1010, "end_changed");
      step(1, 0, 0, 4'b1110, "closed_change");

      // Unchanged window must flag exactly one cycle after end_event
      step(1, 1, 0, 4'b0101, "open_const");
      step(1, 0, 0, 4'b0101, "const1");
      step(1, 0, 0, 4'b0101, "const2");
      step(1, 0, 1, 4'b0101, "end_const");
      step(1, 0, 0, 4'b0101, "after_viol");

      // Change in the closing cycle counts; then back-to-back window
      step(1, 1, 0, 4'b0011, "open_b2b");
      step(1, 0, 1, 4'b0100, "end_with_change");
      step(1, 1, 0, 4'b0100, "b2b_open");
      step(1, 0, 0, 4'b0100, "b2b_const");
      step(1, 1, 1, 4'b0100, "b2b_end_start");
      step(1, 0, 0, 4'b0100, "b2b_idle");

      // start and end together in IDLE: open, end ignored
      step(1, 1, 1, 4'b0001, "start_end_idle");
      // enable low holds everything and silences fire
      step(0, 1, 1, 4'b1111, "disabled");
      step(0, 0, 0, 4'b0111, "disabled2");
      step(1, 0, 1, 4'b0001, "end_after_hold");

      // X/Z inside a window, then reset mid-window
      step(1, 1, 0, 4'b1001, "open_x");
      xval = 4'b1x01;
      step(1, 0, 0, xval, "xz_sample");
      step(1, 0, 0, 4'b1001, "post_xz");
      async_reset("rst_mid_window");
      step(1, 0, 1, 4'b1001, "rst_end_held");
      reset = 1'b0;
      step(1, 0, 1, 4'b1001, "end_after_rst");
      step(1, 1, 0, 4'b0000, "open_after_rst");
      step(1, 0, 1, 4'b0000, "end_after_rst_win");

      // Random traffic with a narrow value range so unchanged windows occur
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            async_reset("rnd_rst");
            step(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), "rnd_rst_held");
            reset = 1'b0;
         end
         step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 4) == 0), W'($urandom_range(0, 2)), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
